// File: rtl/clock_monitor.sv
// Frequency monitor: counts CLK_MON rising edges over a fixed CLK gate window and tracks lock.
// Define CLOCK_MONITOR_DUTY_EN to add the HIGH_COUNT high-time output.
module clock_monitor #(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_WIDTH   = 16,
  parameter int EXP_MIN     = 0,
  parameter int EXP_MAX     = 0,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 CLK_MON,
  output logic [CNT_WIDTH-1:0] COUNT,
  output logic                 VALID,
  output logic                 IN_RANGE,
  output logic                 LOCKED,
  output logic                 LOST
`ifdef CLOCK_MONITOR_DUTY_EN
  , output logic [CNT_WIDTH-1:0] HIGH_COUNT
`endif
);
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_N = LW'(LOCK_COUNT);
  localparam logic [31:0] MIN_U = EXP_MIN;
  localparam logic [31:0] MAX_U = EXP_MAX;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           arm_cnt;
  logic                 sync1, sync2, prev;
  logic [GW-1:0]        gate;
  logic [CNT_WIDTH-1:0] edge_cnt, edge_nxt;
  logic [LW-1:0]        good, good_nxt;
  logic [31:0]          count32;
  logic                 rise, gate_end, win_ok;

  always_ff @(posedge CLK) begin
    if (RST) {sync1, sync2, prev} <= 3'b000;
    else     {sync1, sync2, prev} <= {CLK_MON, sync1, sync2};
  end

  always_comb begin
    rise     = sync2 & ~prev;
    gate_end = (state == MEASURE) && (gate == GATE_LAST);
    // Edge seen in the closing cycle still belongs to this window
    edge_nxt = (rise && edge_cnt != CNT_MAX) ? edge_cnt + 1'b1 : edge_cnt;
    count32  = 32'(edge_nxt);
    win_ok   = (count32 >= MIN_U) && (count32 <= MAX_U);
    good_nxt = (good == LOCK_N) ? good : good + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (!EN) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (arm_cnt == 2'd2) state_nxt = MEASURE;
        MEASURE: state_nxt = MEASURE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      arm_cnt  <= '0;
      gate     <= '0;
      edge_cnt <= '0;
      good     <= '0;
      COUNT    <= '0;
      VALID    <= 1'b0;
      IN_RANGE <= 1'b0;
      LOCKED   <= 1'b0;
      LOST     <= 1'b0;
    end else begin
      VALID <= 1'b0;
      LOST  <= 1'b0;
      if (!EN) begin
        arm_cnt  <= '0;
        gate     <= '0;
        edge_cnt <= '0;
        good     <= '0;
        LOCKED   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            arm_cnt  <= '0;
            gate     <= '0;
            edge_cnt <= '0;
          end
          ARM: arm_cnt <= arm_cnt + 1'b1;
          MEASURE: begin
            if (gate_end) begin
              gate     <= '0;
              edge_cnt <= '0;
              COUNT    <= edge_nxt;
              IN_RANGE <= win_ok;
              VALID    <= 1'b1;
              if (win_ok) begin
                good   <= good_nxt;
                LOCKED <= (good_nxt == LOCK_N);
              end else begin
                good   <= '0;
                LOCKED <= 1'b0;
                LOST   <= LOCKED;
              end
            end else begin
              gate     <= gate + 1'b1;
              edge_cnt <= edge_nxt;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CLOCK_MONITOR_DUTY_EN
  logic [CNT_WIDTH-1:0] high_cnt, high_nxt;

  always_comb high_nxt = (sync2 && high_cnt != CNT_MAX) ? high_cnt + 1'b1 : high_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      high_cnt   <= '0;
      HIGH_COUNT <= '0;
    end else if (!EN || state != MEASURE) begin
      high_cnt <= '0;
    end else if (gate_end) begin
      high_cnt   <= '0;
      HIGH_COUNT <= high_nxt;
    end else begin
      high_cnt <= high_nxt;
    end
  end
`endif
endmodule

// File: tb/tb_clock_monitor.sv
// Randomized bench for clock_monitor: two instances (16-bit and saturating 4-bit counters)
// compared every cycle against a window-level edge-count model.
module tb_clock_monitor;
  localparam int G = 100;

  logic clk = 1'b0;
  logic rst, en, clk_mon;
  always #5 clk = ~clk;

  logic [15:0] count_a;
  logic [3:0]  count_b;
  logic valid_a, inr_a, locked_a, lost_a;
  logic valid_b, inr_b, locked_b, lost_b;
`ifdef CLOCK_MONITOR_DUTY_EN
  logic [15:0] high_a;
  logic [3:0]  high_b;
`endif

  clock_monitor #(.GATE_CYCLES(G), .CNT_WIDTH(16), .EXP_MIN(24), .EXP_MAX(26), .LOCK_COUNT(4)) dut_a (
    .CLK(clk), .RST(rst), .EN(en), .CLK_MON(clk_mon),
    .COUNT(count_a), .VALID(valid_a), .IN_RANGE(inr_a), .LOCKED(locked_a), .LOST(lost_a)
`ifdef CLOCK_MONITOR_DUTY_EN
    , .HIGH_COUNT(high_a)
`endif
  );

  clock_monitor #(.GATE_CYCLES(G), .CNT_WIDTH(4), .EXP_MIN(24), .EXP_MAX(26), .LOCK_COUNT(4)) dut_b (
    .CLK(clk), .RST(rst), .EN(en), .CLK_MON(clk_mon),
    .COUNT(count_b), .VALID(valid_b), .IN_RANGE(inr_b), .LOCKED(locked_b), .LOST(lost_b)
`ifdef CLOCK_MONITOR_DUTY_EN
    , .HIGH_COUNT(high_b)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: h[k] is CLK_MON as sampled at edge k; the DUT sees an edge at k when h[k-2]=1, h[k-3]=0.
  bit h[$];
  int cyc = 0;
  bit active = 0;
  int start = 0;
  bit chk_on = 0;
  bit exp_valid = 0;
  int exp_cnt[2], exp_high[2], good[2];
  bit exp_inr[2], exp_lock[2], exp_lost[2];
  int maxv[2] = '{65535, 15};

  always @(posedge clk) begin
    exp_valid = 0;
    exp_lost  = '{0, 0};
    if (rst) begin
      h.push_back(1'b0);
      active = 0;
      chk_on = 1;
      for (int i = 0; i < 2; i++) begin
        exp_cnt[i] = 0; exp_high[i] = 0; good[i] = 0;
        exp_inr[i] = 0; exp_lock[i] = 0;
      end
    end else begin
      h.push_back(clk_mon);
      if (!en) begin
        active = 0;
        good = '{0, 0};
        exp_lock = '{0, 0};
      end else if (!active) begin
        active = 1;
        start = cyc;
      end else if ((cyc - start) >= 3 + G && ((cyc - start - 3) % G) == 0) begin
        int raw, hi;
        raw = 0; hi = 0;
        for (int k = cyc - G + 1; k <= cyc; k++) begin
          if (h[k-2] && !h[k-3]) raw++;
          if (h[k-2]) hi++;
        end
        exp_valid = 1;
        for (int i = 0; i < 2; i++) begin
          exp_cnt[i]  = (raw > maxv[i]) ? maxv[i] : raw;
          exp_high[i] = (hi > maxv[i]) ? maxv[i] : hi;
          exp_inr[i]  = (exp_cnt[i] >= 24 && exp_cnt[i] <= 26);
          if (exp_inr[i]) begin
            good[i] = (good[i] < 4) ? good[i] + 1 : 4;
            exp_lock[i] = (good[i] == 4);
          end else begin
            exp_lost[i] = exp_lock[i];
            good[i] = 0;
            exp_lock[i] = 0;
          end
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid_a", valid_a, exp_valid);
      chk("count_a", count_a, exp_cnt[0]);
      chk("inr_a", inr_a, exp_inr[0]);
      chk("locked_a", locked_a, exp_lock[0]);
      chk("lost_a", lost_a, exp_lost[0]);
      chk("valid_b", valid_b, exp_valid);
      chk("count_b", count_b, exp_cnt[1]);
      chk("inr_b", inr_b, exp_inr[1]);
      chk("locked_b", locked_b, exp_lock[1]);
      chk("lost_b", lost_b, exp_lost[1]);
`ifdef CLOCK_MONITOR_DUTY_EN
      chk("high_a", high_a, exp_high[0]);
      chk("high_b", high_b, exp_high[1]);
`endif
    end
  end

  // Stimulus: mode 0 = held low, 1 = periodic (per/hi), 2 = random bits
  int mode = 0, per = 4, hi = 1, ph = 0;

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      case (mode)
        0: clk_mon = 1'b0;
        1: begin
          clk_mon = (ph < hi);
          ph = (ph + 1) % per;
        end
        default: clk_mon = 1'($urandom);
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clk_mon = 1'b0;
    run(3);
    rst = 1'b0;
    run(2);
    // nominal CLK/4, lock after four windows
    mode = 1; per = 4; hi = 1; ph = int'($urandom_range(0, 3));
    en = 1'b1;
    run(3 + 6 * G + 5);
    // monitored clock stops: LOST
    mode = 0;
    run(2 * G);
    // relock, then a single-cycle EN drop
    mode = 1;
    run(5 * G);
    en = 1'b0;
    run(1);
    en = 1'b1;
    run(5 * G + 10);
    // reset mid-window
    run(int'($urandom_range(40, 60)));
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(3 + 2 * G + 10);
    // enable dropped mid-window
    run(int'($urandom_range(20, 80)));
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(3 + 2 * G + 10);
    // CLK/2: saturates the 4-bit instance
    per = 2; hi = 1;
    run(3 * G);
    // random data, then random periodic clocks
    mode = 2;
    run(2 * G);
    for (int r = 0; r < 3; r++) begin
      mode = 1;
      per = int'($urandom_range(3, 6));
      hi = int'($urandom_range(1, per - 1));
      run(2 * G);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
